// File: rtl/config_loader_pkg.sv
// Shared constants and types for the config loader slice.
//   ClockConfigWidth / ScaleWidth : default field widths of the config word
//   ShiftRegSize                  : total config word length
//   state_t                       : loader FSM states
//   Default*                      : reset contents of the config shift-register store
package config_pkg;

    localparam int unsigned ClockConfigWidth = 4;
    localparam int unsigned ScaleWidth       = 6;
    localparam int unsigned ShiftRegSize     = 2 * ScaleWidth + ClockConfigWidth;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ClockConfigWidth-1:0] DefaultClockConfig = 4'hF;
    localparam logic [ScaleWidth-1:0]       DefaultAdcScale    = 6'd24;
    localparam logic [ScaleWidth-1:0]       DefaultDacScale    = 6'd12;

    // Packed {dac, adc, clockConfig}, i.e. 16'h318F.
    localparam logic [ShiftRegSize-1:0] DefaultWord =
        {DefaultDacScale, DefaultAdcScale, DefaultClockConfig};

endpackage

// File: rtl/config_loader_if.sv
// Command / response bus of the config loader.
//   master : issues cmdValid + cmdWrite + new config word, sees cmdReady,
//            rspValid, the previous config word and busy
//   slave  : the loader side
interface config_loader_if #(
    parameter int unsigned ClockConfigWidth = config_pkg::ClockConfigWidth,
    parameter int unsigned ScaleWidth       = config_pkg::ScaleWidth
);

    logic                        cmdValid;
    logic                        cmdReady;
    logic                        cmdWrite;
    logic [ClockConfigWidth-1:0] cmdClockConfig;
    logic [ScaleWidth-1:0]       cmdAdcScale;
    logic [ScaleWidth-1:0]       cmdDacScale;

    logic                        rspValid;
    logic [ClockConfigWidth-1:0] rspClockConfig;
    logic [ScaleWidth-1:0]       rspAdcScale;
    logic [ScaleWidth-1:0]       rspDacScale;

    logic                        busy;

    modport master (
        output cmdValid, cmdWrite, cmdClockConfig, cmdAdcScale, cmdDacScale,
        input  cmdReady, rspValid, rspClockConfig, rspAdcScale, rspDacScale, busy
    );

    modport slave (
        input  cmdValid, cmdWrite, cmdClockConfig, cmdAdcScale, cmdDacScale,
        output cmdReady, rspValid, rspClockConfig, rspAdcScale, rspDacScale, busy
    );

endinterface

// File: rtl/config_loader_shift_tick.sv
// Serial shift strobe generator: counts 0..ShiftDivide-1 while enabled and
// pulses tick_o on the last count.
//   clk, reset : clock, synchronous active-high reset
//   enable_i   : count while high
//   clear_i    : force the count back to 0 (has priority over enable_i)
//   tick_o     : one-cycle strobe when enabled and the count is ShiftDivide-1
module shift_tick #(
    parameter int unsigned ShiftDivide = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    if (ShiftDivide < 1 || ShiftDivide > 16) begin : g_bad_divide
        $error("shift_tick: ShiftDivide must be in 1..16");
    end

    localparam int unsigned   CntW = (ShiftDivide > 1) ? $clog2(ShiftDivide) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(ShiftDivide - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == LastCount);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LastCount) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/config_store.sv
// Config shift-register store: N-bit register that shifts serialIn_i into
// its LSB on each serialEn_i cycle and exposes its MSB on serialOut_o.
//   clk, reset     : clock, synchronous active-high reset (loads defaults)
//   serialEn_i     : shift strobe
//   serialIn_i     : serial data in (LSB side)
//   serialOut_o    : MSB tap
//   clockConfig_o, adcScale_o, dacScale_o : current stored fields
module config_store #(
    parameter int unsigned ClockConfigWidth = config_pkg::ClockConfigWidth,
    parameter int unsigned ScaleWidth       = config_pkg::ScaleWidth
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serialEn_i,
    input  logic                        serialIn_i,
    output logic                        serialOut_o,
    output logic [ClockConfigWidth-1:0] clockConfig_o,
    output logic [ScaleWidth-1:0]       adcScale_o,
    output logic [ScaleWidth-1:0]       dacScale_o
);

    import config_pkg::*;

    localparam int unsigned N = 2 * ScaleWidth + ClockConfigWidth;
    localparam logic [N-1:0] ResetWord = {ScaleWidth'(DefaultDacScale),
                                          ScaleWidth'(DefaultAdcScale),
                                          ClockConfigWidth'(DefaultClockConfig)};

    logic [N-1:0] word_q, word_d;

    assign serialOut_o   = word_q[N-1];
    assign dacScale_o    = word_q[N-1 -: ScaleWidth];
    assign adcScale_o    = word_q[ClockConfigWidth +: ScaleWidth];
    assign clockConfig_o = word_q[ClockConfigWidth-1:0];

    always_comb begin
        word_d = word_q;
        if (serialEn_i) begin
            word_d = {word_q[N-2:0], serialIn_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= ResetWord;
        end else begin
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/config_loader.sv
// Config loader: serially writes or reads (by recirculation) the config
// shift-register store, MSB first, returning the word that was in the store
// before the operation.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : command/response interface (slave side)
//   cfgSerialEn  : store shift enable
//   cfgSerialIn  : store serial data in
//   cfgSerialOut : store MSB tap
module config_loader #(
    parameter int unsigned ClockConfigWidth = config_pkg::ClockConfigWidth,
    parameter int unsigned ScaleWidth       = config_pkg::ScaleWidth,
    parameter int unsigned ShiftDivide      = 1
) (
    input  logic             clk,
    input  logic             reset,
    config_loader_if.slave   bus,
    output logic             cfgSerialEn,
    output logic             cfgSerialIn,
    input  logic             cfgSerialOut
);

    import config_pkg::*;

    localparam int unsigned      N       = 2 * ScaleWidth + ClockConfigWidth;
    localparam int unsigned      BitW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [BitW-1:0]  LastBit = BitW'(N - 1);

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [N-1:0]    tx_q, tx_d;
    logic [N-1:0]    rx_q, rx_d;
    logic [N-1:0]    rsp_q, rsp_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic            tick;
    logic            in_shift;

    assign in_shift = (state_q == SHIFT);

    shift_tick #(
        .ShiftDivide(ShiftDivide)
    ) u_shift_tick (
        .clk      (clk),
        .reset    (reset),
        .enable_i (in_shift),
        .clear_i  (!in_shift),
        .tick_o   (tick)
    );

    assign cfgSerialEn = tick;
    // Read recirculates the store's own MSB, so the store ends unchanged.
    assign cfgSerialIn = in_shift ? (write_q ? tx_q[N-1] : cfgSerialOut) : 1'b0;

    assign bus.cmdReady       = (state_q == IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.rspValid       = (state_q == DONE);
    assign bus.rspDacScale    = rsp_q[N-1 -: ScaleWidth];
    assign bus.rspAdcScale    = rsp_q[ClockConfigWidth +: ScaleWidth];
    assign bus.rspClockConfig = rsp_q[ClockConfigWidth-1:0];

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rsp_d   = rsp_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (bus.cmdValid) begin
                    state_d = SHIFT;
                    write_d = bus.cmdWrite;
                    tx_d    = {bus.cmdDacScale, bus.cmdAdcScale, bus.cmdClockConfig};
                    rx_d    = '0;
                    bit_d   = LastBit;
                end
            end
            SHIFT: begin
                if (tick) begin
                    rx_d = {rx_q[N-2:0], cfgSerialOut};
                    tx_d = {tx_q[N-2:0], 1'b0};
                    if (bit_q == '0) begin
                        // Response register is loaded on the DONE entry edge so
                        // the fields are already valid alongside rspValid.
                        state_d = DONE;
                        rsp_d   = {rx_q[N-2:0], cfgSerialOut};
                    end else begin
                        bit_d = bit_q - BitW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rsp_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rsp_q   <= rsp_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench: two loaders (ShiftDivide 1 and 4), each paired with its own
// config store on a shared clk/reset.
module tb_config_loader;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    config_loader_if #(.ClockConfigWidth(4), .ScaleWidth(6)) if1 ();
    config_loader_if #(.ClockConfigWidth(4), .ScaleWidth(6)) if4 ();

    logic        cmdValid1 = 1'b0;
    logic        cmdValid4 = 1'b0;
    logic        cmdWrite  = 1'b0;
    logic [15:0] cmdWord   = 16'h0000;
    logic        sel4      = 1'b0;

    assign if1.cmdValid       = cmdValid1;
    assign if1.cmdWrite       = cmdWrite;
    assign if1.cmdDacScale    = cmdWord[15:10];
    assign if1.cmdAdcScale    = cmdWord[9:4];
    assign if1.cmdClockConfig = cmdWord[3:0];
    assign if4.cmdValid       = cmdValid4;
    assign if4.cmdWrite       = cmdWrite;
    assign if4.cmdDacScale    = cmdWord[15:10];
    assign if4.cmdAdcScale    = cmdWord[9:4];
    assign if4.cmdClockConfig = cmdWord[3:0];

    logic       en1, sin1, sout1, en4, sin4, sout4;
    logic [3:0] st1_clk, st4_clk;
    logic [5:0] st1_adc, st1_dac, st4_adc, st4_dac;

    config_loader #(.ClockConfigWidth(4), .ScaleWidth(6), .ShiftDivide(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1),
        .cfgSerialEn(en1), .cfgSerialIn(sin1), .cfgSerialOut(sout1)
    );
    config_store #(.ClockConfigWidth(4), .ScaleWidth(6)) u_store1 (
        .clk(clk), .reset(reset), .serialEn_i(en1), .serialIn_i(sin1),
        .serialOut_o(sout1), .clockConfig_o(st1_clk), .adcScale_o(st1_adc), .dacScale_o(st1_dac)
    );
    config_loader #(.ClockConfigWidth(4), .ScaleWidth(6), .ShiftDivide(4)) u_dut4 (
        .clk(clk), .reset(reset), .bus(if4),
        .cfgSerialEn(en4), .cfgSerialIn(sin4), .cfgSerialOut(sout4)
    );
    config_store #(.ClockConfigWidth(4), .ScaleWidth(6)) u_store4 (
        .clk(clk), .reset(reset), .serialEn_i(en4), .serialIn_i(sin4),
        .serialOut_o(sout4), .clockConfig_o(st4_clk), .adcScale_o(st4_adc), .dacScale_o(st4_dac)
    );

    wire [15:0] store1_word = {st1_dac, st1_adc, st1_clk};
    wire [15:0] store4_word = {st4_dac, st4_adc, st4_clk};
    wire [15:0] rsp1_word   = {if1.rspDacScale, if1.rspAdcScale, if1.rspClockConfig};
    wire [15:0] rsp4_word   = {if4.rspDacScale, if4.rspAdcScale, if4.rspClockConfig};

    wire        obs_en    = sel4 ? en4 : en1;
    wire        obs_sin   = sel4 ? sin4 : sin1;
    wire        obs_ready = sel4 ? if4.cmdReady : if1.cmdReady;
    wire        obs_rspv  = sel4 ? if4.rspValid : if1.rspValid;
    wire [15:0] obs_rsp   = sel4 ? rsp4_word : rsp1_word;

    // Issues one command from a negedge (cycle 0 = accept cycle) and records
    // per-cycle observations until cmdReady returns after the response.
    task automatic run_cmd(input logic use4, input logic wr, input logic [15:0] word,
                           input logic noise, input int max_cycles,
                           output int n_en, output int first_en, output int last_en,
                           output int n_rsp, output int rsp_cycle, output int ready_cycle,
                           output logic [15:0] rsp_word, output logic sin_ok);
        logic prev_sin;
        logic prev_en;
        sel4 = use4;
        n_en = 0; first_en = -1; last_en = -1; n_rsp = 0;
        rsp_cycle = -1; ready_cycle = -1; rsp_word = 16'hxxxx; sin_ok = 1'b1;
        prev_sin = 1'b0; prev_en = 1'b0;
        cmdWrite = wr;
        cmdWord  = word;
        if (use4) cmdValid4 = 1'b1; else cmdValid1 = 1'b1;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmdValid1 = 1'b0;
                cmdValid4 = 1'b0;
            end
            if (obs_en) begin
                n_en++;
                if (first_en < 0) first_en = k;
                last_en = k;
            end
            if (k >= 2 && obs_sin !== prev_sin && !prev_en) sin_ok = 1'b0;
            prev_sin = obs_sin;
            prev_en  = obs_en;
            if (obs_rspv) begin
                n_rsp++;
                if (rsp_cycle < 0) begin
                    rsp_cycle = k;
                    rsp_word  = obs_rsp;
                end
            end
            if (noise && k >= 2) begin
                if (rsp_cycle >= 0) begin
                    cmdValid1 = 1'b0;
                    cmdValid4 = 1'b0;
                end else begin
                    if (use4) cmdValid4 = k[0]; else cmdValid1 = k[0];
                    cmdWord  = word ^ 16'(k * 977);
                    cmdWrite = ~wr;
                end
            end
            if (rsp_cycle >= 0 && obs_ready) begin
                ready_cycle = k;
                break;
            end
        end
        cmdValid1 = 1'b0;
        cmdValid4 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (if1.cmdReady !== 1'b1) $display("FAIL reset_ready: got %b want 1", if1.cmdReady); else passed++;
        checks++; if (en1 !== 1'b0 || sin1 !== 1'b0) $display("FAIL reset_serial: got en=%b in=%b want 0 0", en1, sin1); else passed++;
        checks++; if (if1.rspValid !== 1'b0 || if1.busy !== 1'b0) $display("FAIL reset_rsp_busy: got %b %b want 0 0", if1.rspValid, if1.busy); else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (rsp1_word !== 16'h0000 || rsp4_word !== 16'h0000) $display("FAIL reset_rsp_fields: got %h %h want 0000", rsp1_word, rsp4_word); else passed++;
        checks++; if (store1_word !== 16'h318F) $display("FAIL reset_store: got %h want 318f", store1_word); else passed++;
        checks++; if (if1.cmdReady !== 1'b1 || if4.cmdReady !== 1'b1) $display("FAIL reset_ready_after: got %b %b want 1 1", if1.cmdReady, if4.cmdReady); else passed++;
    endtask

    task automatic test_read();
        int n_en, f_en, l_en, n_rsp, rc, yc;
        logic [15:0] rw;
        logic so;
        run_cmd(1'b0, 1'b0, 16'hFFFF, 1'b0, 40, n_en, f_en, l_en, n_rsp, rc, yc, rw, so);
        checks++; if (rw !== 16'h318F) $display("FAIL read_rsp: got %h want 318f", rw); else passed++;
        checks++; if (n_en !== 16) $display("FAIL read_enables: got %0d want 16", n_en); else passed++;
        checks++; if (f_en !== 1 || l_en !== 16) $display("FAIL read_enable_window: got %0d..%0d want 1..16", f_en, l_en); else passed++;
        checks++; if (rc !== 17 || n_rsp !== 1) $display("FAIL read_rsp_timing: got cycle %0d count %0d want 17 1", rc, n_rsp); else passed++;
        checks++; if (yc !== 18) $display("FAIL read_ready_again: got %0d want 18", yc); else passed++;
        checks++; if (store1_word !== 16'h318F) $display("FAIL read_store_unchanged: got %h want 318f", store1_word); else passed++;
    endtask

    task automatic test_write();
        int n_en, f_en, l_en, n_rsp, rc, yc;
        logic [15:0] rw;
        logic so;
        run_cmd(1'b0, 1'b1, 16'h1683, 1'b0, 40, n_en, f_en, l_en, n_rsp, rc, yc, rw, so);
        checks++; if (rw !== 16'h318F) $display("FAIL write_rsp_old: got %h want 318f", rw); else passed++;
        checks++; if (st1_dac !== 6'd5 || st1_adc !== 6'd40 || st1_clk !== 4'd3) $display("FAIL write_store: got dac %0d adc %0d clk %0d want 5 40 3", st1_dac, st1_adc, st1_clk); else passed++;
        checks++; if (rc !== 17 || n_en !== 16) $display("FAIL write_timing: got rsp %0d en %0d want 17 16", rc, n_en); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (rsp1_word !== 16'h318F) $display("FAIL write_rsp_hold: got %h want 318f", rsp1_word); else passed++;
        run_cmd(1'b0, 1'b0, 16'h0000, 1'b0, 40, n_en, f_en, l_en, n_rsp, rc, yc, rw, so);
        checks++; if (rw !== 16'h1683) $display("FAIL write_readback: got %h want 1683", rw); else passed++;
    endtask

    task automatic test_divide4();
        int n_en, f_en, l_en, n_rsp, rc, yc;
        logic [15:0] rw;
        logic so;
        run_cmd(1'b1, 1'b0, 16'h0000, 1'b0, 120, n_en, f_en, l_en, n_rsp, rc, yc, rw, so);
        checks++; if (n_en !== 16 || f_en !== 4 || l_en !== 64) $display("FAIL div4_enables: got %0d at %0d..%0d want 16 at 4..64", n_en, f_en, l_en); else passed++;
        checks++; if (rc !== 65 || n_rsp !== 1 || yc !== 66) $display("FAIL div4_timing: got rsp %0d x%0d ready %0d want 65 x1 66", rc, n_rsp, yc); else passed++;
        checks++; if (so !== 1'b1) $display("FAIL div4_read_sin_stable: got %b want 1", so); else passed++;
        checks++; if (rw !== 16'h318F) $display("FAIL div4_read_rsp: got %h want 318f", rw); else passed++;
        run_cmd(1'b1, 1'b1, 16'h1683, 1'b0, 120, n_en, f_en, l_en, n_rsp, rc, yc, rw, so);
        checks++; if (so !== 1'b1) $display("FAIL div4_write_sin_stable: got %b want 1", so); else passed++;
        checks++; if (store4_word !== 16'h1683 || rw !== 16'h318F) $display("FAIL div4_write: got store %h rsp %h want 1683 318f", store4_word, rw); else passed++;
        sel4 = 1'b0;
    endtask

    task automatic test_ignore_during_shift();
        int n_en, f_en, l_en, n_rsp, rc, yc;
        int busy_seen;
        logic [15:0] rw;
        logic so;
        run_cmd(1'b0, 1'b1, 16'h0F0F, 1'b1, 40, n_en, f_en, l_en, n_rsp, rc, yc, rw, so);
        checks++; if (n_rsp !== 1 || n_en !== 16 || yc !== 18) $display("FAIL ignore_counts: got rsp %0d en %0d ready %0d want 1 16 18", n_rsp, n_en, yc); else passed++;
        checks++; if (rw !== 16'h1683) $display("FAIL ignore_rsp: got %h want 1683", rw); else passed++;
        checks++; if (store1_word !== 16'h0F0F) $display("FAIL ignore_store: got %h want 0f0f", store1_word); else passed++;
        busy_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (if1.busy) busy_seen++;
        end
        checks++; if (busy_seen !== 0) $display("FAIL ignore_not_queued: got %0d busy cycles want 0", busy_seen); else passed++;
        cmdWrite = 1'b0;
        cmdWord  = 16'h0000;
    endtask

    task automatic test_back_to_back();
        int r1, r2, nr;
        logic busy19;
        logic [15:0] w2;
        r1 = -1; r2 = -1; nr = 0; busy19 = 1'b0; w2 = 16'hxxxx;
        sel4 = 1'b0;
        cmdWrite  = 1'b0;
        cmdWord   = 16'h0000;
        cmdValid1 = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (if1.rspValid) begin
                nr++;
                if (r1 < 0) r1 = k;
                else if (r2 < 0) begin
                    r2 = k;
                    w2 = rsp1_word;
                end
            end
            if (k == 19) begin
                busy19    = if1.busy;
                cmdValid1 = 1'b0;
            end
            if (r2 >= 0 && if1.cmdReady) break;
        end
        cmdValid1 = 1'b0;
        checks++; if (r1 !== 17 || r2 !== 35 || nr !== 2) $display("FAIL b2b_rsp: got %0d,%0d x%0d want 17,35 x2", r1, r2, nr); else passed++;
        checks++; if (busy19 !== 1'b1) $display("FAIL b2b_immediate_accept: got busy %b want 1", busy19); else passed++;
        checks++; if (w2 !== 16'h0F0F) $display("FAIL b2b_rsp_word: got %h want 0f0f", w2); else passed++;
    endtask

    task automatic test_reset_abort();
        int n_en, f_en, l_en, n_rsp, rc, yc, en_at7, nr;
        logic [15:0] rw;
        logic so;
        en_at7 = 0; nr = 0;
        sel4 = 1'b0;
        cmdWrite  = 1'b1;
        cmdWord   = 16'h1683;
        cmdValid1 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            cmdValid1 = 1'b0;
            if (en1) en_at7++;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if1.rspValid) nr++;
        end
        checks++; if (en_at7 !== 7) $display("FAIL abort_shift_count: got %0d want 7", en_at7); else passed++;
        checks++; if (nr !== 0) $display("FAIL abort_no_rsp: got %0d want 0", nr); else passed++;
        checks++; if (if1.cmdReady !== 1'b1 || if1.busy !== 1'b0) $display("FAIL abort_idle: got ready %b busy %b want 1 0", if1.cmdReady, if1.busy); else passed++;
        checks++; if (store1_word !== 16'h318F || rsp1_word !== 16'h0000) $display("FAIL abort_defaults: got store %h rsp %h want 318f 0000", store1_word, rsp1_word); else passed++;
        run_cmd(1'b0, 1'b0, 16'h0000, 1'b0, 40, n_en, f_en, l_en, n_rsp, rc, yc, rw, so);
        checks++; if (rw !== 16'h318F || n_rsp !== 1) $display("FAIL abort_then_read: got %h x%0d want 318f x1", rw, n_rsp); else passed++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_divide4();
        test_ignore_during_shift();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter ClockConfigWidth, default 4, width of the clock-config field.
REQ-002 Parameter ScaleWidth, default 6, width of each of the ADC and DAC scale fields.
REQ-003 Parameter ShiftDivide, default 1, clk cycles per serial shift; legal range is 1..16.
REQ-004 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 cmdValid  in  1  command request; cmdReady  out  1  loader idle and accepting.
REQ-006 cmdWrite  in  1  1 = write the new word, 0 = read by recirculation (store unchanged).
REQ-007 cmdClockConfig  in  ClockConfigWidth, cmdAdcScale  in  ScaleWidth, cmdDacScale  in  ScaleWidth  new config word.
REQ-008 cfgSerialEn  out  1, cfgSerialIn  out  1  drive the config shift-register enable and data.
REQ-009 cfgSerialOut  in  1  MSB tap of the config shift register.
REQ-010 rspValid  out  1  one-cycle completion pulse.
REQ-011 rspClockConfig, rspAdcScale, rspDacScale  out  field widths  config word present before the operation.
REQ-012 busy  out  1  high in SHIFT and DONE.

Function
REQ-013 Word N = 2*ScaleWidth + ClockConfigWidth bits, packed as {dac, adc, clockConfig}, and shifted MSB first.
REQ-014 FSM states and transitions: IDLE -> SHIFT on cmdValid&&cmdReady; SHIFT -> DONE after the N-th enabled shift; DONE -> IDLE unconditionally.
REQ-015 cmdReady = 1 only in IDLE; command fields and cmdWrite are latched on acceptance, and later input changes have no effect.
REQ-016 In SHIFT, a divider counts 0..ShiftDivide-1, and cfgSerialEn = 1 exactly on the cycle the count equals ShiftDivide-1, else 0.
REQ-017 cfgSerialIn = latched tx MSB when cmdWrite = 1, and = cfgSerialOut (combinational) when cmdWrite = 0; it is held stable between enables and is 0 outside SHIFT.
REQ-018 On each cfgSerialEn cycle, cfgSerialOut is shifted into the LSB of the rx register and the tx register shifts left by one.
REQ-019 Exactly N enable pulses occur per command; a bit counter runs N-1 down to 0 with no wrap.
REQ-020 In DONE, rspValid = 1 for one cycle and the rsp fields update to the rx register; the rsp fields hold until the next DONE.
REQ-021 Latency with ShiftDivide = 1: accept cycle t, enables on t+1..t+N, rspValid at t+N+1, cmdReady high again at t+N+2.
REQ-022 General latency: rspValid at t + N*ShiftDivide + 1.
REQ-023 cmdValid asserted during SHIFT or DONE is ignored and is not queued.
REQ-024 Back-to-back commands: a command held valid is accepted on the first IDLE cycle.

Reset
REQ-025 Reset drives state IDLE, all counters to 0, tx/rx to 0, rspValid 0, rsp fields 0, cfgSerialEn 0, cfgSerialIn 0, and cmdReady 1 on the first cycle after reset.
REQ-026 Reset during SHIFT aborts with no rspValid; store contents are the store's own reset values (shared reset).

Structure
REQ-027 Package config_pkg holds ClockConfigWidth, ScaleWidth, the derived ShiftRegSize, the state enum {IDLE, SHIFT, DONE}, and the store default values.
REQ-028 A single sub-module, shift_tick, implements the ShiftDivide strobe counter (enable, clear, tick out); everything else stays inline.

Verification
REQ-029 Bench pairs the loader with the existing config shift-register store on shared clk/reset.
REQ-030 After reset, issue read (cmdWrite = 0) -> rsp = {dac 12, adc 24, clk 0xF} (word 0x318F), and the store is unchanged afterwards.
REQ-031 Write {dac 5, adc 40, clk 3} (0x1683) -> rsp = 0x318F, and the store outputs dac 5, adc 40, clk 3 after DONE.
REQ-032 With ShiftDivide = 1, accept at cycle 0 -> exactly 16 enables on cycles 1..16, rspValid on cycle 17 only, cmdReady high on cycle 18.
REQ-033 With ShiftDivide = 4 -> an enable every 4th cycle, cfgSerialIn stable for 4 cycles, and rspValid at cycle 65.
REQ-034 cmdValid toggled with changing data during SHIFT -> no effect, and exactly one rspValid.
REQ-035 Reset asserted at shift 7 -> no rspValid, loader in IDLE and store at defaults; a following read returns 0x318F.
